// File: rtl/interp_sequencer.sv
// Four-phase interpolating sequencer: buffers an 8-tap pixel window, then emits the
// pass-through sample and three filtered sub-pixel values with rounding and clamping.
module interp_sequencer #(
  parameter int SHIFT = 6
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic [1:0]  out_phase,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sat_count
);

  typedef enum logic [1:0] {
    S_FILL,
    S_EMIT,
    S_WAIT
  } state_e;

  localparam logic signed [15:0] ROUND = 16'sd1 <<< (SHIFT - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [7:0]         r_buf [8];
  logic [3:0]         r_fill_cnt;
  logic [1:0]         r_phase;
  logic [15:0]        r_sat_count;

  logic               w_accept;
  logic               w_xfer;
  logic signed [15:0] w_s [8];
  logic signed [15:0] w_sum;
  logic signed [15:0] w_round;
  logic [7:0]         w_data;
  logic               w_clamped;

  // Handshake outputs depend only on the state register.
  assign in_ready  = (r_state != S_EMIT);
  assign out_valid = (r_state == S_EMIT);
  assign out_phase = r_phase;
  assign out_data  = w_data;
  assign sat_count = r_sat_count;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_FILL;
    end else begin
      unique case (r_state)
        S_FILL:  if (w_accept && r_fill_cnt == 4'd7) w_next_state = S_EMIT;
        S_EMIT:  if (w_xfer && r_phase == 2'd3)      w_next_state = S_WAIT;
        S_WAIT:  if (w_accept)                       w_next_state = S_EMIT;
        default: w_next_state = S_FILL;
      endcase
    end
  end

  // NOTE: the sample buffer is small and must read back as zero after reset,
  // so it lives in flops with the async reset rather than in a RAM.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 8; k++) r_buf[k] <= 8'd0;
      r_fill_cnt  <= 4'd0;
      r_phase     <= 2'd0;
      r_sat_count <= 16'd0;
    end else begin
      if (w_xfer && w_clamped && r_sat_count != 16'hFFFF) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
      if (flush) begin
        for (int k = 0; k < 8; k++) r_buf[k] <= 8'd0;
        r_fill_cnt <= 4'd0;
        r_phase    <= 2'd0;
      end else begin
        if (w_accept) begin
          r_buf[0] <= in_data;
          for (int k = 1; k < 8; k++) r_buf[k] <= r_buf[k-1];
          if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + 4'd1;
          r_phase <= 2'd0;
        end
        if (w_xfer) r_phase <= r_phase + 2'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) w_s[k] = $signed({8'd0, r_buf[k]});
  end

  // Tap sets for the 1/4, 1/2 and 3/4 sub-pixel positions; each sums to 64.
  always_comb begin
    w_sum = 16'sd0;
    unique case (r_phase)
      2'd1: w_sum = 16'sd4 * w_s[6] - w_s[7] - 16'sd10 * w_s[5] + 16'sd58 * w_s[4]
                  + 16'sd17 * w_s[3] - 16'sd5 * w_s[2] + w_s[1];
      2'd2: w_sum = 16'sd4 * w_s[6] - w_s[7] - 16'sd11 * w_s[5] + 16'sd40 * w_s[4]
                  + 16'sd40 * w_s[3] - 16'sd11 * w_s[2] + 16'sd4 * w_s[1] - w_s[0];
      2'd3: w_sum = w_s[6] - 16'sd5 * w_s[5] + 16'sd17 * w_s[4] + 16'sd58 * w_s[3]
                  - 16'sd10 * w_s[2] + 16'sd4 * w_s[1] - w_s[0];
      default: w_sum = 16'sd0;
    endcase
  end

  always_comb begin
    w_round   = (w_sum + ROUND) >>> SHIFT;
    w_data    = w_round[7:0];
    w_clamped = 1'b0;
    if (r_phase == 2'd0) begin
      w_data = r_buf[4];
    end else if (w_round < 16'sd0) begin
      w_data    = 8'd0;
      w_clamped = 1'b1;
    end else if (w_round > 16'sd255) begin
      w_data    = 8'd255;
      w_clamped = 1'b1;
    end
  end

endmodule

// File: tb/tb_interp_sequencer.sv
// Scoreboard bench for interp_sequencer: stimulus pushes expected outputs, a negedge
// monitor pops and compares on every output transfer.
module tb_interp_sequencer;

  logic        clock = 1'b0;
  logic        reset_L = 1'b1;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_phase;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sat_count;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] phase;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] imp [8] = '{8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] neg [8] = '{8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  interp_sequencer #(.SHIFT(6)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_count (sat_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clock) begin
    if (reset_L && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got data %0d phase %0d, expected none", out_data, out_phase);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", int'(out_data), int'(mon_e.data));
        check("out_phase", int'(out_phase), int'(mon_e.phase));
      end
    end
  end

  task automatic expect_window(input int d0, input int d1, input int d2, input int d3);
    exp_t e;
    e.data = d0[7:0]; e.phase = 2'd0; sb_q.push_back(e);
    e.data = d1[7:0]; e.phase = 2'd1; sb_q.push_back(e);
    e.data = d2[7:0]; e.phase = 2'd2; sb_q.push_back(e);
    e.data = d3[7:0]; e.phase = 2'd3; sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL feed_timeout: in_ready stayed 0, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (sb_q.size() == 0) begin
        step();
        return;
      end
      @(negedge clock);
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d outputs pending, expected 0", sb_q.size());
    sb_q.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_phase"}, int'(out_phase), 0);
    check({tag, "_sat_count"}, int'(sat_count), 0);
  endtask

  initial begin
    flush     = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    #1 reset_L = 1'b0;
    #3;
    check_reset_values("reset");
    @(negedge clock);
    reset_L = 1'b1;
    step();

    // Constant stream: 12 samples give one full window plus four single-sample windows.
    for (int i = 0; i < 12; i++) begin
      if (i >= 7) expect_window(100, 100, 100, 100);
      feed(8'd100);
    end
    drain();
    check("const_sat_count", int'(sat_count), 0);

    // Impulse at b4.
    do_flush();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(200, 181, 125, 53);
      feed(imp[i]);
    end
    drain();
    @(negedge clock);
    check("wait_in_ready", int'(in_ready), 1);
    check("wait_out_valid", int'(out_valid), 0);

    // Impulse at b5 drives all filtered phases negative.
    do_flush();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(0, 0, 0, 0);
      feed(neg[i]);
    end
    drain();
    check("neg_sat_count", int'(sat_count), 3);

    // Backpressure held at phase 2 for five cycles with a competing input offered.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(200, 181, 125, 53);
      feed(imp[i]);
    end
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    in_data   = 8'd77;
    in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_phase", int'(out_phase), 2);
      check("stall_out_data", int'(out_data), 125);
      check("stall_in_ready", int'(in_ready), 0);
    end
    step();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain();

    // Flush colliding with an input accept in the middle of EMIT.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) feed(8'd50);
    check("pre_flush_out_valid", int'(out_valid), 1);
    flush    = 1'b1;
    in_data  = 8'd99;
    in_valid = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_in_ready", int'(in_ready), 1);
    check("flush_out_phase", int'(out_phase), 0);
    check("flush_out_data", int'(out_data), 0);
    check("flush_sat_count", int'(sat_count), 3);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) feed(imp[i]);
    repeat (3) step();
    check("flush_7_samples_no_valid", int'(out_valid), 0);
    expect_window(200, 181, 125, 53);
    feed(imp[7]);
    drain();

    // Asynchronous reset in the middle of EMIT.
    out_ready = 1'b0;
    feed(8'd100);
    check("pre_reset_out_valid", int'(out_valid), 1);
    #2 reset_L = 1'b0;
    #1;
    check_reset_values("midemit_reset");
    @(negedge clock);
    reset_L   = 1'b1;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) feed(8'd100);
    repeat (3) step();
    check("reset_7_samples_no_valid", int'(out_valid), 0);
    expect_window(100, 100, 100, 100);
    feed(8'd100);
    drain();
    check("final_sat_count", int'(sat_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interp_sequencer.md
INTERP_SEQUENCER -- requirements
Module: interp_sequencer

Interface
REQ-001 The module SHALL have parameter SHIFT, default 6, giving the normalisation right-shift applied to every filter sum.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port flush, input, 1 bit: synchronous clear back to the FILL state.
REQ-005 The module SHALL have ports in_data (input, 8 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): the unsigned pixel input stream.
REQ-006 The module SHALL have ports out_data (output, 8 bits), out_phase (output, 2 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): the interpolated output stream.
REQ-007 The module SHALL have port sat_count, output, 16 bits: saturating count of clamp events.

Function
REQ-008 The module SHALL hold an 8-entry, 8-bit shift buffer b0..b7; on an input accept, b0 SHALL receive in_data and every bk SHALL move to bk+1, with old b7 discarded.
REQ-009 The module SHALL treat an input accept as in_valid & in_ready, and an output transfer as out_valid & out_ready.
REQ-010 The FSM SHALL have three states: FILL, EMIT and WAIT.
REQ-011 In FILL: in_ready=1, out_valid=0, and a 4-bit fill counter increments per accept; the 8th accept SHALL enter EMIT with phase=0.
REQ-012 In EMIT: in_ready=0, out_valid=1, out_phase=phase.
- Each output transfer SHALL advance phase by 1.
- The transfer at phase 3 SHALL enter WAIT.
REQ-013 In WAIT: in_ready=1, out_valid=0; an accept SHALL shift the buffer and enter EMIT with phase=0.
REQ-014 The phase outputs SHALL be as follows, all sums 16-bit signed:
- phase0: out_data = b4 (pass-through).
- phase1: A = -b7 +4b6 -10b5 +58b4 +17b3 -5b2 +b1.
- phase2: B = -b7 +4b6 -11b5 +40b4 +40b3 -11b2 +4b1 -b0.
- phase3: C = b6 -5b5 +17b4 +58b3 -10b2 +4b1 -b0.
REQ-015 For phases 1-3, out_data SHALL be r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), clamped to [0,255].
REQ-016 Every output transfer in which clamping altered r SHALL increment sat_count, which SHALL hold at 0xFFFF.
REQ-017 out_data and out_phase SHALL be functions of registered state only, with no combinational path from in_* or out_ready.
REQ-018 out_data, out_phase and out_valid SHALL stay stable while out_valid=1 and out_ready=0, for any number of stall cycles.
REQ-019 The latency from the input accept that completes the window to out_valid=1 SHALL be exactly 1 cycle.
REQ-020 Each window SHALL produce exactly 4 output transfers, and no input SHALL be accepted between them.
REQ-021 flush=1 SHALL, on the next edge, clear the buffer, fill counter, phase and state to FILL and drop any pending outputs; sat_count SHALL be unaffected.
REQ-022 When flush and an input accept coincide, flush SHALL win and the sample SHALL be discarded.
REQ-023 While in_valid=0 in FILL or WAIT, the FSM SHALL hold its state indefinitely.

Reset
REQ-024 reset_L=0 SHALL immediately force: state=FILL, buffer=0, fill counter=0, phase=0, sat_count=0, out_valid=0, out_data=0, out_phase=0, in_ready=1.
REQ-025 A reset asserted mid-EMIT SHALL abandon the remaining phases, and no stale output SHALL appear after release.
REQ-026 After reset_L deasserts, the first accept SHALL occur no earlier than the next rising edge.

Verification
REQ-027 Constant stream: feed 100 x 12 with out_ready=1 -> outputs 100,100,100,100 for every window, sat_count=0.
REQ-028 Impulse: feed 0,0,0,200,0,0,0,0 -> phases 0..3 give 200,181,125,53, then in_ready=1 in WAIT.
REQ-029 Negative clamp: feed 0,0,200,0,0,0,0,0 (b5=200) -> outputs 0,0,0,0, sat_count=3.
REQ-030 Backpressure: out_ready=0 for 5 cycles at phase 2 -> out_data and out_phase held, in_ready=0 throughout, then phase 3 follows after release.
REQ-031 Flush/reset: assert flush while an in_valid accept coincides mid-EMIT -> state FILL, that sample dropped; reset_L low mid-EMIT -> all outputs at reset values asynchronously, and 8 new samples are needed before the next out_valid.
